// File: rtl/simple_cpu_pkg.sv
// Shared types for the simple CPU control path: opcodes, FSM states, instruction layout.
package simple_cpu_pkg;

  localparam int unsigned IR_W  = 9;
  localparam int unsigned FLD_W = 3;

  localparam logic [FLD_W-1:0] OP_MV  = 3'b000;
  localparam logic [FLD_W-1:0] OP_MVI = 3'b001;
  localparam logic [FLD_W-1:0] OP_ADD = 3'b010;
  localparam logic [FLD_W-1:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // IR[8:6] opcode, IR[5:3] destination Rx, IR[2:0] source Ry
  typedef struct packed {
    logic [FLD_W-1:0] op;
    logic [FLD_W-1:0] rx;
    logic [FLD_W-1:0] ry;
  } ir_t;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y = 8'(1) << sel;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM for the simple CPU (mv, mvi, add, sub) over a shared bus.
// Optional ALU_SEQ_CTRL_INSTCNT_EN adds a retired-legal-instruction counter (instcnt).
module alu_seq_ctrl
  import simple_cpu_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            run,
  input  logic [DW-1:0]   din,
  output logic            irin,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            gout,
  output logic            dinout,
  output logic            ain,
  output logic            gin,
  output logic            sub,
  output logic            done
`ifdef ALU_SEQ_CTRL_INSTCNT_EN
  ,
  output logic [15:0]     instcnt
`endif
);

  state_t     state_q, state_d;
  ir_t        ir_q, ir_d;
  logic       rin_en, rout_en;
  logic [2:0] rin_sel, rout_sel;

  // Only the low 9 bits carry an instruction; the rest of din feeds the datapath.
  logic unused_din_hi;
  assign unused_din_hi = ^din[DW-1:IR_W];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs are pure decodes of (state, IR, run), forced quiet while in reset.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    irin     = 1'b0;
    rin_en   = 1'b0;
    rin_sel  = ir_q.rx;
    rout_en  = 1'b0;
    rout_sel = ir_q.ry;
    gout     = 1'b0;
    dinout   = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    sub      = 1'b0;
    done     = 1'b0;
    if (resetn) begin
      case (state_q)
        T0: begin
          if (run) begin
            irin    = 1'b1;
            ir_d    = ir_t'(din[IR_W-1:0]);
            state_d = T1;
          end
        end
        T1: begin
          state_d = T0;
          case (ir_q.op)
            OP_MV: begin
              rout_en = 1'b1;
              rin_en  = 1'b1;
              done    = 1'b1;
            end
            OP_MVI: begin
              dinout = 1'b1;
              rin_en = 1'b1;
              done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              rout_en  = 1'b1;
              rout_sel = ir_q.rx;
              ain      = 1'b1;
              state_d  = T2;
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          rout_en = 1'b1;
          gin     = 1'b1;
          sub     = ir_q.op[0];
          state_d = T3;
        end
        T3: begin
          gout    = 1'b1;
          rin_en  = 1'b1;
          done    = 1'b1;
          state_d = T0;
        end
        default: state_d = T0;
      endcase
    end
  end

  dec3to8 u_rin_dec (
    .en  (rin_en),
    .sel (rin_sel),
    .y   (rin)
  );

  dec3to8 u_rout_dec (
    .en  (rout_en),
    .sel (rout_sel),
    .y   (rout)
  );

`ifdef ALU_SEQ_CTRL_INSTCNT_EN
  // Illegal opcodes (op[2] set) retire but are not counted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      instcnt <= '0;
    end else if (done && (ir_q.op <= OP_SUB)) begin
      instcnt <= instcnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed scenarios plus randomized traffic vs. a schedule model.
module tb_alu_seq_ctrl;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        irin;
  logic [7:0]  rin;
  logic [7:0]  rout;
  logic        gout, dinout, ain, gin, sub, done;
`ifdef ALU_SEQ_CTRL_INSTCNT_EN
  logic [15:0] instcnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  alu_seq_ctrl #(.DW(16), .NREG(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .irin   (irin),
    .rin    (rin),
    .rout   (rout),
    .gout   (gout),
    .dinout (dinout),
    .ain    (ain),
    .gin    (gin),
    .sub    (sub),
    .done   (done)
`ifdef ALU_SEQ_CTRL_INSTCNT_EN
    ,
    .instcnt(instcnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       sub;
    logic       done;
  } outv_t;

  typedef struct packed {
    outv_t o;
    logic  legal;
  } step_t;

  // Expected outputs for the cycles after an instruction is accepted.
  step_t       sched[$];
  logic [15:0] mcnt;

  function automatic void build(input logic [8:0] ins);
    logic [2:0] op, x, y;
    step_t s;
    op = ins[8:6];
    x  = ins[5:3];
    y  = ins[2:0];
    s = '0;
    s.legal = (op < 3'd4);
    if (op == 3'd0) begin
      s.o.rout = 8'(1) << y; s.o.rin = 8'(1) << x; s.o.done = 1'b1;
      sched.push_back(s);
    end else if (op == 3'd1) begin
      s.o.dinout = 1'b1; s.o.rin = 8'(1) << x; s.o.done = 1'b1;
      sched.push_back(s);
    end else if (op == 3'd2 || op == 3'd3) begin
      s.o.rout = 8'(1) << x; s.o.ain = 1'b1;
      sched.push_back(s);
      s.o = '0;
      s.o.rout = 8'(1) << y; s.o.gin = 1'b1; s.o.sub = (op == 3'd3);
      sched.push_back(s);
      s.o = '0;
      s.o.gout = 1'b1; s.o.rin = 8'(1) << x; s.o.done = 1'b1;
      sched.push_back(s);
    end else begin
      s.o.done = 1'b1;
      sched.push_back(s);
    end
  endfunction

  // Check mid-cycle, then advance the model on the following rising edge.
  always begin
    outv_t act, expv;
    int    nsrc;
    @(negedge clock);
    act = {irin, rin, rout, gout, dinout, ain, gin, sub, done};
    if (!resetn) begin
      sched.delete();
      mcnt = 16'd0;
      expv = '0;
    end else if (sched.size() != 0) begin
      expv = sched[0].o;
    end else begin
      expv = '0;
      expv.irin = run;
    end
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL outputs @%0t: got %h expected %h", $time, act, expv);
    end
    nsrc = $countones(rout) + int'(gout) + int'(dinout);
    n_vec++;
    if (nsrc > 1 || !$onehot0(rin) || !$onehot0(rout)) begin
      n_miss++;
      $display("FAIL exclusivity @%0t: rout=%h rin=%h gout=%b dinout=%b", $time, rout, rin, gout, dinout);
    end
`ifdef ALU_SEQ_CTRL_INSTCNT_EN
    n_vec++;
    if (instcnt !== mcnt) begin
      n_miss++;
      $display("FAIL instcnt @%0t: got %h expected %h", $time, instcnt, mcnt);
    end
`endif
    @(posedge clock);
    if (resetn) begin
      if (sched.size() != 0) begin
        if (sched[0].o.done && sched[0].legal) mcnt = mcnt + 16'd1;
        void'(sched.pop_front());
      end else if (run) begin
        build(din[8:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Apply inputs just after a rising edge and return mid-cycle with outputs settled.
  task automatic cyc(input logic r, input logic [15:0] d, input logic rn);
    @(posedge clock);
    #1;
    run    = r;
    din    = d;
    resetn = rn;
    @(negedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b1;
    din    = 16'h0050;
    mcnt   = 16'd0;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h0050, 1'b0);
      chk("reset_irin", 16'(irin), 16'h0);
      chk("reset_done", 16'(done), 16'h0);
    end
    cyc(1'b0, 16'h0000, 1'b1);
    chk("idle_irin", 16'(irin), 16'h0);

    // mvi R2, 0x00A5
    cyc(1'b1, 16'h0050, 1'b1);
    chk("mvi_irin", 16'(irin), 16'h1);
    cyc(1'b0, 16'h00A5, 1'b1);
    chk("mvi_dinout", 16'(dinout), 16'h1);
    chk("mvi_rin", 16'(rin), 16'h0004);
    chk("mvi_done", 16'(done), 16'h1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("mvi_after_done", 16'(done), 16'h0);

    // add R1,R5
    cyc(1'b1, 16'h008D, 1'b1);
    chk("add_irin", 16'(irin), 16'h1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("add_t1_rout", 16'(rout), 16'h0002);
    chk("add_t1_ain", 16'(ain), 16'h1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("add_t2_rout", 16'(rout), 16'h0020);
    chk("add_t2_gin", 16'(gin), 16'h1);
    chk("add_t2_sub", 16'(sub), 16'h0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("add_t3_gout", 16'(gout), 16'h1);
    chk("add_t3_rin", 16'(rin), 16'h0002);
    chk("add_t3_done", 16'(done), 16'h1);

    // mv R7,R3 then sub R0,R0 back-to-back with run held
    cyc(1'b1, 16'h003B, 1'b1);
    chk("mv_irin", 16'(irin), 16'h1);
    cyc(1'b1, 16'h00C0, 1'b1);
    chk("mv_rout", 16'(rout), 16'h0008);
    chk("mv_rin", 16'(rin), 16'h0080);
    chk("mv_done", 16'(done), 16'h1);
    chk("mv_irin_ignored", 16'(irin), 16'h0);
    cyc(1'b1, 16'h00C0, 1'b1);
    chk("sub_irin", 16'(irin), 16'h1);
    cyc(1'b1, 16'h0000, 1'b1);
    chk("sub_t1_rout", 16'(rout), 16'h0001);
    chk("sub_t1_sub", 16'(sub), 16'h0);
    cyc(1'b1, 16'h0000, 1'b1);
    chk("sub_t2_rout", 16'(rout), 16'h0001);
    chk("sub_t2_sub", 16'(sub), 16'h1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("sub_t3_sub", 16'(sub), 16'h0);
    chk("sub_t3_rin", 16'(rin), 16'h0001);
    chk("sub_t3_done", 16'(done), 16'h1);

    // illegal opcode 110
    cyc(1'b1, 16'h0180, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("ill_done", 16'(done), 16'h1);
    chk("ill_enables", {rin, rout}, 16'h0000);
    chk("ill_ctrl", 16'({gout, dinout, ain, gin}), 16'h0);
`ifdef ALU_SEQ_CTRL_INSTCNT_EN
    cyc(1'b0, 16'h0000, 1'b1);
    chk("ill_instcnt", instcnt, 16'd4);
`endif

    // add R3,R3 interrupted by reset in T2, then mv R4,R3
    cyc(1'b1, 16'h009B, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("rst_t1_rout", 16'(rout), 16'h0008);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("rst_gin", 16'(gin), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("rst_no_done", 16'(done), 16'h0);
    cyc(1'b1, 16'h0023, 1'b1);
    chk("post_rst_irin", 16'(irin), 16'h1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("post_rst_rin", 16'(rin), 16'h0010);
    chk("post_rst_rout", 16'(rout), 16'h0008);
    chk("post_rst_done", 16'(done), 16'h1);

    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 63) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
